// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam int DATA_W = 8;

  // Number of FEED cycles needed for the last product to reach PE(n-1,n-1).
  function automatic int feed_cycles(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One edge lane of the skewed feed: picks element (t - idx) of a latched
// row/column, or 0 when that index falls outside 0..N-1.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int TW = 4,
  parameter int IW = 2
) (
  input  logic [N*DATA_W-1:0] i_vec,
  input  logic [IW-1:0]       i_idx,
  input  logic [TW-1:0]       i_t,
  output logic [DATA_W-1:0]   o_elem
);

  localparam int KW = TW + IW + 1;

  // Both operands zero-extended into a signed word so t < idx goes negative.
  logic signed [KW-1:0] w_k;
  assign w_k = $signed({{(IW + 1){1'b0}}, i_t}) - $signed({{(TW + 1){1'b0}}, i_idx});

  always_comb begin
    o_elem = '0;
    for (int k = 0; k < N; k++) begin
      if (w_k == $signed(KW'(k))) o_elem = i_vec[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic multiplier: latches A and B,
// streams them diagonally skewed into the array edges, then holds results.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_start,
  input  logic [N*N*DATA_W-1:0] i_matA,
  input  logic [N*N*DATA_W-1:0] i_matB,
  input  logic                  i_ack,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_doProcess,
  output logic [N*DATA_W-1:0]   o_a,
  output logic [N*DATA_W-1:0]   o_b
);

  localparam int TW = $clog2(3 * N - 1);
  localparam int IW = $clog2(N);
  localparam logic [TW-1:0] T_LAST = TW'(feed_cycles(N) - 1);

  ctrl_state_t           r_state;
  ctrl_state_t           w_next;
  logic [TW-1:0]         r_t;
  logic [N*N*DATA_W-1:0] r_matA;
  logic [N*N*DATA_W-1:0] r_matB;
  logic [N*DATA_W-1:0]   w_a;
  logic [N*DATA_W-1:0]   w_b;
  logic                  w_take;

  assign w_take = (r_state == IDLE) && i_start;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_t    <= '0;
      r_matA <= '0;
      r_matB <= '0;
    end else if (w_take) begin
      r_t    <= '0;
      r_matA <= i_matA;
      r_matB <= i_matB;
    end else if (r_state == FEED && r_t != T_LAST) begin
      r_t <= r_t + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = FEED;
      FEED:    if (r_t == T_LAST) w_next = DONE;
      DONE:    if (i_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Lane g of A takes row g directly; lane g of B needs column g gathered.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [N*DATA_W-1:0] w_col;
    for (genvar k = 0; k < N; k++) begin : g_col
      assign w_col[k*DATA_W +: DATA_W] = r_matB[(k*N+g)*DATA_W +: DATA_W];
    end

    systolic_skew_lane #(.N(N), .TW(TW), .IW(IW)) u_lane_a (
      .i_vec  (r_matA[g*N*DATA_W +: N*DATA_W]),
      .i_idx  (IW'(g)),
      .i_t    (r_t),
      .o_elem (w_a[g*DATA_W +: DATA_W])
    );

    systolic_skew_lane #(.N(N), .TW(TW), .IW(IW)) u_lane_b (
      .i_vec  (w_col),
      .i_idx  (IW'(g)),
      .i_t    (r_t),
      .o_elem (w_b[g*DATA_W +: DATA_W])
    );
  end

  // DONE keeps doProcess high with zero operands so the accumulators hold.
  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_doProcess = 1'b0;
    o_a         = '0;
    o_b         = '0;
    case (r_state)
      FEED: begin
        o_busy      = 1'b1;
        o_doProcess = 1'b1;
        o_a         = w_a;
        o_b         = w_b;
      end
      DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        o_doProcess = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: phase-level reference model of the feed, a
// behavioural PE grid driven by the DUT, and directed scenarios.
module tb_systolic_ctrl;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             start = 1'b0;
  logic             ack = 1'b0;
  logic [N*N*W-1:0] matA = '0;
  logic [N*N*W-1:0] matB = '0;
  logic             busy, done, dop;
  logic [N*W-1:0]   oa, ob;

  int total = 0;
  int bad = 0;

  int         tA[N][N];
  int         tB[N][N];
  int         acc[N][N];
  logic [7:0] pa[N][N];
  logic [7:0] pb[N][N];

  int         m_ph;
  int         m_t;
  logic [7:0] mA[N][N];
  logic [7:0] mB[N][N];

  logic [N*W-1:0] snapA[16];
  logic [N*W-1:0] snapB[16];
  int nf;

  systolic_ctrl #(.N(N)) dut (
    .i_clk       (clk),
    .i_arst_n    (arst_n),
    .i_start     (start),
    .i_matA      (matA),
    .i_matB      (matB),
    .i_ack       (ack),
    .o_busy      (busy),
    .o_done      (done),
    .o_doProcess (dop),
    .o_a         (oa),
    .o_b         (ob)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Phase model: 0 idle, 1 feeding at step m_t, 2 results held.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_ph <= 0;
      m_t  <= 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          mA[i][j] <= '0;
          mB[i][j] <= '0;
        end
    end else begin
      case (m_ph)
        0: if (start) begin
          m_ph <= 1;
          m_t  <= 0;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              mA[i][j] <= matA[(i*N+j)*W +: W];
              mB[i][j] <= matB[(i*N+j)*W +: W];
            end
        end
        1: if (m_t == 3*N-3) m_ph <= 2; else m_t <= m_t + 1;
        default: if (ack) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic [N*W-1:0] ea, eb;
    ea = '0;
    eb = '0;
    if (m_ph == 1) begin
      for (int r = 0; r < N; r++) begin
        if (m_t - r >= 0 && m_t - r < N) begin
          ea[r*W +: W] = mA[r][m_t-r];
          eb[r*W +: W] = mB[m_t-r][r];
        end
      end
    end
    check("busy", busy, m_ph != 0);
    check("done", done, m_ph == 2);
    check("doProcess", dop, m_ph != 0);
    check("o_a", oa, ea);
    check("o_b", ob, eb);
  end

  // Output-stationary PE grid: operands re-registered right/down, clear when idle.
  always @(posedge clk) begin : pe_grid
    logic [7:0] ai, bi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ai = oa[i*W +: W]; else ai = pa[i][j-1];
        if (i == 0) bi = ob[j*W +: W]; else bi = pb[i-1][j];
        if (dop) acc[i][j] <= acc[i][j] + int'(ai) * int'(bi);
        else     acc[i][j] <= 0;
        pa[i][j] <= ai;
        pb[i][j] <= bi;
      end
    end
  end

  function automatic int refy(input int i, input int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += tA[i][k] * tB[k][j];
    return s;
  endfunction

  task automatic set_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        matA[(i*N+j)*W +: W] = tA[i][j][7:0];
        matB[(i*N+j)*W +: W] = tB[i][j][7:0];
      end
  endtask

  task automatic start_op();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int ps, input int pk, input logic [N*N*W-1:0] alt,
                                output int nfeed);
    nfeed = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) break;
      if (k < 16) begin
        snapA[k] = oa;
        snapB[k] = ob;
      end
      if (dop) nfeed++;
      start = (k == ps);
      ack   = (k == pk);
      if (k == ps) matA = alt;
      @(negedge clk);
    end
    start = 1'b0;
    ack   = 1'b0;
    check("done_reached", done, 1);
  endtask

  task automatic check_y();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("y[%0d][%0d]", i, j), acc[i][j], refy(i, j));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pa[i][j] = '0;
        pb[i][j] = '0;
      end

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dop", dop, 0);
    check("rst_oa", oa, 0);
    check("rst_ob", ob, 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_dop", dop, 0);

    // Identity x ramp
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tA[i][j] = (i == j) ? 1 : 0;
        tB[i][j] = 4*i + j + 1;
      end
    set_mats();
    start_op();
    run_until_done(-1, -1, '0, nf);
    check("feed_cycles", nf, 10);
    check("a0_t0", snapA[0][7:0], 1);
    check("a1_t0", snapA[0][15:8], 0);
    check("a1_t2", snapA[2][15:8], 1);
    check("b1_t1", snapB[1][15:8], 2);
    check("y00_lit", acc[0][0], 1);
    check("y33_lit", acc[3][3], 16);
    check("y12_lit", acc[1][2], 7);
    check_y();
    do_ack();

    // Saturation, with start pulsed at t=4 and ack pulsed at t=2 during FEED
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tA[i][j] = 255;
        tB[i][j] = 255;
      end
    set_mats();
    start_op();
    run_until_done(4, 2, '0, nf);
    check("sat_feed_cycles", nf, 10);
    check("sat_y12_lit", acc[1][2], 260100);
    check_y();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_done", done, 1);
      check("hold_y00", acc[0][0], 260100);
      check("hold_y33", acc[3][3], 260100);
    end
    ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    check("ackstart_idle", busy, 0);
    @(negedge clk);
    check("start_dropped", busy, 0);

    // Abort at t=5, then a fresh multiply
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tA[i][j] = i + j + 1;
        tB[i][j] = 2*i - j + 5;
      end
    set_mats();
    start_op();
    repeat (5) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_dop", dop, 0);
    check("abort_oa", oa, 0);
    check("abort_ob", ob, 0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tA[i][j] = (3*i + j) % 7 + 1;
        tB[i][j] = (i * j) % 5 + 2;
      end
    set_mats();
    start_op();
    run_until_done(-1, -1, '0, nf);
    check("abort_next_feed", nf, 10);
    check_y();

    // Back-to-back: ack at Ex, start at Ex+1 with new matrices
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("b2b_idle", busy, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tA[i][j] = 1;
        tB[i][j] = 2;
      end
    set_mats();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_done(-1, -1, '0, nf);
    check("b2b_feed", nf, 10);
    check("b2b_y21_lit", acc[2][1], 8);
    check_y();
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
